// File: rtl/burst_ram_responder_pkg.sv
// Shared types and constants for the burst-RAM responder.
package burst_ram_responder_pkg;

  localparam int unsigned DATA_WIDTH = 64;
  localparam int unsigned MASK_WIDTH = 8;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StWriteBurst,
    StReadWait,
    StReadBurst
  } state_e;

endpackage

// File: rtl/burst_ram_bytes.sv
// Simple dual-port RAM, 64-bit words, per-byte write enables, registered read.
module burst_ram_bytes
  import burst_ram_responder_pkg::*;
#(
  parameter int unsigned DEPTH_BITWIDTH = 12
) (
  input  logic                      clk,
  input  logic [MASK_WIDTH-1:0]     wr_be,
  input  logic [DEPTH_BITWIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic                      rd_en,
  input  logic [DEPTH_BITWIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]     rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**DEPTH_BITWIDTH];

  // Byte-granular write port.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < MASK_WIDTH; i++) begin
      if (wr_be[i]) begin
        mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Registered read port; output holds between reads.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/burst_ram_responder.sv
// Responder side of the 64-bit burst-RAM command interface, backed by an inferred RAM.
// Mimics the memory IP timing: calibration delay, fixed read latency, fixed burst length.
module burst_ram_responder
  import burst_ram_responder_pkg::*;
#(
  parameter int unsigned ADDRESS_BITWIDTH         = 21,
  parameter int unsigned DEPTH_BITWIDTH           = 12,
  parameter int unsigned BURST_BEATS              = 4,
  parameter int unsigned CYCLES_BEFORE_INITIATED  = 10,
  parameter int unsigned CYCLES_BEFORE_DATA_VALID = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cmd,
  input  logic                        cmd_en,
  input  logic [ADDRESS_BITWIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  input  logic [MASK_WIDTH-1:0]       data_mask,
  output logic [DATA_WIDTH-1:0]       rd_data,
  output logic                        rd_data_valid,
  output logic                        init_calib,
  output logic                        busy,
  output logic                        cmd_error
);

  localparam int unsigned InitCntW = $clog2(CYCLES_BEFORE_INITIATED + 1);
  localparam int unsigned WaitCntW = $clog2(CYCLES_BEFORE_DATA_VALID);
  localparam int unsigned BeatCntW = $clog2(BURST_BEATS + 1);

  localparam logic [InitCntW-1:0] InitLast = InitCntW'(CYCLES_BEFORE_INITIATED - 1);
  // First RAM read goes out one cycle before the first valid beat.
  localparam logic [WaitCntW-1:0] WaitLast = WaitCntW'(CYCLES_BEFORE_DATA_VALID - 2);
  localparam logic [BeatCntW-1:0] BeatLast = BeatCntW'(BURST_BEATS - 1);
  localparam logic [BeatCntW-1:0] BeatEnd  = BeatCntW'(BURST_BEATS);

  state_e                    state_q;
  logic [InitCntW-1:0]       init_cnt_q;
  logic [WaitCntW-1:0]       wait_cnt_q;
  logic [BeatCntW-1:0]       beat_cnt_q;
  logic [DEPTH_BITWIDTH-1:0] addr_q;
  logic                      busy_q;
  logic                      init_calib_q;
  logic                      cmd_error_q;
  logic                      rd_valid_q;

  logic [DEPTH_BITWIDTH-1:0] base;
  logic                      in_burst;
  logic [MASK_WIDTH-1:0]     ram_we;
  logic [DEPTH_BITWIDTH-1:0] ram_waddr;
  logic                      ram_re;
  logic [DEPTH_BITWIDTH-1:0] ram_raddr;
  logic [DATA_WIDTH-1:0]     ram_rdata;

  assign base     = addr[DEPTH_BITWIDTH-1:0];
  assign in_burst = (state_q == StWriteBurst) || (state_q == StReadWait) ||
                    (state_q == StReadBurst);

  // RAM port control: beat 0 of a write goes straight in during the command cycle.
  always_comb begin
    ram_we    = '0;
    ram_waddr = addr_q;
    ram_re    = 1'b0;
    ram_raddr = addr_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_en && (cmd == CMD_WRITE)) begin
          ram_we    = ~data_mask;
          ram_waddr = base;
        end
      end
      StWriteBurst: ram_we = ~data_mask;
      StReadWait:   ram_re = (wait_cnt_q == WaitLast);
      StReadBurst:  ram_re = (beat_cnt_q != BeatEnd);
      default: ;
    endcase
  end

  // Main FSM with counters and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StInit;
      init_cnt_q   <= '0;
      wait_cnt_q   <= '0;
      beat_cnt_q   <= '0;
      addr_q       <= '0;
      busy_q       <= 1'b0;
      init_calib_q <= 1'b0;
      cmd_error_q  <= 1'b0;
      rd_valid_q   <= 1'b0;
    end else begin
      rd_valid_q <= ram_re;
      // Commands are ignored outside IDLE; flag the misuse and keep going.
      if (cmd_en && ((state_q == StInit) || in_burst)) begin
        cmd_error_q <= 1'b1;
      end
      unique case (state_q)
        StInit: begin
          if (init_cnt_q == InitLast) begin
            init_calib_q <= 1'b1;
            state_q      <= StIdle;
          end else begin
            init_cnt_q <= init_cnt_q + 1'b1;
          end
        end
        StIdle: begin
          if (cmd_en) begin
            beat_cnt_q <= BeatCntW'(1);
            wait_cnt_q <= '0;
            if (cmd == CMD_WRITE) begin
              addr_q <= base + 1'b1;
              if (BURST_BEATS > 1) begin
                state_q <= StWriteBurst;
                busy_q  <= 1'b1;
              end
            end else begin
              addr_q  <= base;
              state_q <= StReadWait;
              busy_q  <= 1'b1;
            end
          end
        end
        StWriteBurst: begin
          addr_q <= addr_q + 1'b1;
          if (beat_cnt_q == BeatLast) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
          end
        end
        StReadWait: begin
          if (wait_cnt_q == WaitLast) begin
            addr_q     <= addr_q + 1'b1;
            beat_cnt_q <= BeatCntW'(1);
            state_q    <= StReadBurst;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        StReadBurst: begin
          // One extra cycle after the last issue so busy covers the final valid beat.
          if (beat_cnt_q == BeatEnd) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            addr_q     <= addr_q + 1'b1;
            beat_cnt_q <= beat_cnt_q + 1'b1;
          end
        end
        default: state_q <= StInit;
      endcase
    end
  end

  burst_ram_bytes #(
    .DEPTH_BITWIDTH (DEPTH_BITWIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_be   (ram_we),
    .wr_addr (ram_waddr),
    .wr_data (wr_data),
    .rd_en   (ram_re),
    .rd_addr (ram_raddr),
    .rd_data (ram_rdata)
  );

  assign rd_data       = rd_valid_q ? ram_rdata : '0;
  assign rd_data_valid = rd_valid_q;
  assign init_calib    = init_calib_q;
  assign busy          = busy_q;
  assign cmd_error     = cmd_error_q;

endmodule

// File: tb/tb_burst_ram_responder.sv
// Self-checking bench for burst_ram_responder: reference memory model plus read scoreboard.
module tb_burst_ram_responder;

  localparam int L = 8;
  localparam int B = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd;
  logic        cmd_en;
  logic [20:0] addr;
  logic [63:0] wr_data;
  logic [7:0]  data_mask;
  logic [63:0] rd_data;
  logic        rd_data_valid;
  logic        init_calib;
  logic        busy;
  logic        cmd_error;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] sb_q[$];
  logic [63:0] model[int];
  logic [63:0] mon_exp;

  always #5 clk = ~clk;

  burst_ram_responder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd           (cmd),
    .cmd_en        (cmd_en),
    .addr          (addr),
    .wr_data       (wr_data),
    .data_mask     (data_mask),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid),
    .init_calib    (init_calib),
    .busy          (busy),
    .cmd_error     (cmd_error)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int word_idx(input logic [20:0] a, input int k);
    logic [11:0] w;
    w = a[11:0] + 12'(k);
    return int'(w);
  endfunction

  function automatic void model_write(input int idx, input logic [63:0] d, input logic [7:0] m);
    logic [63:0] cur;
    cur = model.exists(idx) ? model[idx] : 64'h0;
    for (int i = 0; i < 8; i++) begin
      if (!m[i]) cur[8*i +: 8] = d[8*i +: 8];
    end
    model[idx] = cur;
  endfunction

  // Scoreboard consumer: every valid beat must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_data_valid) begin
        if (sb_q.size() == 0) begin
          check_eq("rd_unexpected", 64'(rd_data_valid), 64'h0);
        end else begin
          mon_exp = sb_q.pop_front();
          check_eq("rd_data", rd_data, mon_exp);
        end
      end else begin
        check_eq("rd_data_idle", rd_data, 64'h0);
      end
    end
  end

  task automatic do_write(input logic [20:0] a, input logic [255:0] d, input logic [31:0] m);
    @(negedge clk);
    cmd_en    = 1'b1;
    cmd       = 1'b1;
    addr      = a;
    wr_data   = d[63:0];
    data_mask = m[7:0];
    model_write(word_idx(a, 0), d[63:0], m[7:0]);
    for (int k = 1; k < B; k++) begin
      @(negedge clk);
      cmd_en = 1'b0;
      check_eq("wr_busy", 64'(busy), 64'h1);
      wr_data   = d[64*k +: 64];
      data_mask = m[8*k +: 8];
      model_write(word_idx(a, k), d[64*k +: 64], m[8*k +: 8]);
    end
    @(negedge clk);
    check_eq("wr_done_busy", 64'(busy), 64'h0);
  endtask

  // Issue a read; optionally fire a stray cmd_en at cycle T+inject_at, or reset at beat 2.
  task automatic do_read(input logic [20:0] a, input int inject_at, input bit abort);
    int last;
    @(negedge clk);
    cmd_en = 1'b1;
    cmd    = 1'b0;
    addr   = a;
    for (int k = 0; k < B; k++) sb_q.push_back(model[word_idx(a, k)]);
    last = abort ? L + 1 : L + B;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      cmd_en = 1'b0;
      if (k == inject_at) begin
        cmd_en    = 1'b1;
        cmd       = 1'b1;
        wr_data   = 64'hDEAD_BEEF_DEAD_BEEF;
        data_mask = 8'h00;
      end
      check_eq("rd_valid", 64'(rd_data_valid), 64'((k >= L) && (k < L + B)));
      check_eq("rd_busy", 64'(busy), 64'(k < L + B));
    end
    if (abort) begin
      #1 rst_n = 1'b0;
      #1;
      check_eq("abort_valid", 64'(rd_data_valid), 64'h0);
      check_eq("abort_busy", 64'(busy), 64'h0);
      check_eq("abort_data", rd_data, 64'h0);
      check_eq("abort_init", 64'(init_calib), 64'h0);
      sb_q.delete();
    end
  endtask

  task automatic wait_init();
    int n = 0;
    while (!init_calib && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("init_timeout", 64'(init_calib), 64'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; cmd = 1'b0; cmd_en = 1'b0; addr = '0; wr_data = '0; data_mask = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_rd_data", rd_data, 64'h0);
    check_eq("rst_valid", 64'(rd_data_valid), 64'h0);
    check_eq("rst_init", 64'(init_calib), 64'h0);
    check_eq("rst_busy", 64'(busy), 64'h0);
    check_eq("rst_err", 64'(cmd_error), 64'h0);

    // init_calib low for exactly 10 cycles after release
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1 check_eq("init_low", 64'(init_calib), 64'h0);
      @(posedge clk);
    end
    #1;
    check_eq("init_high", 64'(init_calib), 64'h1);
    check_eq("init_busy", 64'(busy), 64'h0);
    check_eq("init_err", 64'(cmd_error), 64'h0);

    // Basic burst write / read
    do_write(21'h002, {64'h5555_0005, 64'h5555_0004, 64'h5555_0003, 64'h5555_0002}, 32'h0);
    do_write(21'h010, {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}}, 32'h0);
    do_read(21'h010, 0, 1'b0);

    // Byte masks, including a fully masked beat
    do_write(21'h020, {4{64'hFFFF_FFFF_FFFF_FFFF}}, 32'h0);
    do_write(21'h020, {4{64'h0}}, {8'hF0, 8'h00, 8'hFF, 8'h0F});
    do_read(21'h020, 0, 1'b0);

    // Wrap past the top of the RAM, and address aliasing
    do_write(21'h0FFE, {64'hD0D0, 64'hC0C0, 64'hB0B0, 64'hA0A0}, 32'h0);
    do_read(21'h0FFE, 0, 1'b0);
    do_read(21'h1000, 0, 1'b0);

    // Reset during the second valid beat
    do_read(21'h010, 0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    cmd_en = 1'b1;
    cmd    = 1'b0;
    addr   = 21'h010;
    @(negedge clk);
    cmd_en = 1'b0;
    check_eq("err_init", 64'(cmd_error), 64'h1);
    check_eq("err_init_calib", 64'(init_calib), 64'h0);
    wait_init();

    // Stray command at T+3 of a read is ignored
    do_read(21'h010, 3, 1'b0);
    check_eq("err_sticky", 64'(cmd_error), 64'h1);
    do_read(21'h020, 0, 1'b0);
    do_read(21'h0FFE, 0, 1'b0);
    do_write(21'h030, {64'h4, 64'h3, 64'h2, 64'h1}, 32'h0);
    do_read(21'h030, 0, 1'b0);

    @(negedge clk);
    check_eq("sb_left", 64'(sb_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/burst_ram_responder.md
Name: burst_ram_responder

Overview:
- Responder (target) side of the 64-bit burst-RAM command interface (cmd / cmd_en / addr / wr_data / data_mask / rd_data / rd_data_valid / init_calib) that the cache drives as initiator.
- Stands in for the PSRAM memory-interface IP in simulation and BRAM-backed builds, so the cache can be exercised without the PSRAM controller.
- Backs storage with an inferred RAM and reproduces the IP's timing: calibration delay, fixed read latency, fixed-length bursts.

Parameters:
- ADDRESS_BITWIDTH, 21, width of addr; unit is one 64-bit word.
- DEPTH_BITWIDTH, 12, log2 of words actually stored; only the low DEPTH_BITWIDTH bits of every beat address are used.
- BURST_BEATS, 4, 64-bit beats per command (read or write).
- CYCLES_BEFORE_INITIATED, 10, clk cycles after reset release before init_calib rises.
- CYCLES_BEFORE_DATA_VALID, 8, cycles from read cmd_en to first rd_data_valid; legal range is 2 or more.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd  in  1  1 = write, 0 = read; sampled only when cmd_en = 1.
- cmd_en  in  1  one-cycle command strobe.
- addr  in  ADDRESS_BITWIDTH  word address of beat 0.
- wr_data  in  64  write beat data.
- data_mask  in  8  per-byte mask; bit i = 1 means byte i is NOT written.
- rd_data  out  64  read beat data.
- rd_data_valid  out  1  high on each read beat.
- init_calib  out  1  high once ready; stays high until reset.
- busy  out  1  a command is in progress.
- cmd_error  out  1  sticky: a command was issued while not ready or busy.

Behaviour:
- Reset (async assert, sync release):
  - Outputs: rd_data = 0, rd_data_valid = 0, init_calib = 0, busy = 0, cmd_error = 0.
  - State goes to INIT and all counters clear. RAM contents are not cleared.
- INIT: counts CYCLES_BEFORE_INITIATED cycles, then sets init_calib = 1 and enters IDLE.
- IDLE accepts cmd_en. The command address base is addr mod 2^DEPTH_BITWIDTH.
- Write, cmd_en = 1 and cmd = 1 at cycle T:
  - Beat 0 (wr_data, data_mask) is written at base in cycle T.
  - Beats k = 1..BURST_BEATS-1 are taken from wr_data/data_mask at T+k and written to base+k. wr_data/data_mask are sampled every beat cycle regardless of cmd_en.
  - State WRITE_BURST; busy = 1 from T+1 through T+BURST_BEATS-1.
  - Next command accepted at T+BURST_BEATS.
- Read, cmd_en = 1 and cmd = 0 at cycle T:
  - State READ_WAIT, then READ_BURST.
  - rd_data_valid = 1 for cycles T+L .. T+L+BURST_BEATS-1, where L = CYCLES_BEFORE_DATA_VALID. Beat k carries mem[base+k].
  - RAM read is registered, so the read is issued one cycle before each valid beat.
  - busy = 1 from T+1 through the last valid beat; next command accepted the cycle after.
- rd_data is 0 whenever rd_data_valid = 0.
- Beat address increment wraps modulo 2^DEPTH_BITWIDTH; no alignment requirement.
- Masked bytes keep their old value. A fully masked beat (8'hFF) writes nothing.
- cmd_en while in INIT or while busy = 1:
  - The command is ignored and the in-flight operation continues unaffected.
  - cmd_error sets and stays set until reset.
- Reset mid-burst: the burst aborts immediately and outputs return to reset values. Beats already written stay written.
- Read after write to the same address in the next accepted command returns the new data.

Decomposition:
- Shared package holds:
  - state encoding (INIT, IDLE, WRITE_BURST, READ_WAIT, READ_BURST);
  - cmd encodings CMD_READ = 0, CMD_WRITE = 1;
  - DATA_WIDTH = 64, MASK_WIDTH = 8.
- One sub-module, burst_ram_bytes: simple dual-port RAM, 2^DEPTH_BITWIDTH x 64, byte-write-enables, registered read. The top level is FSM, counters and address generation.

Test Plan:
- Release rst_n, hold cmd_en = 0 -> init_calib = 0 for exactly 10 cycles, then 1; busy = 0, cmd_error = 0.
- Write at addr 0x10, beats 0x1111..1, 0x2222..2, 0x3333..3, 0x4444..4, mask 0; read addr 0x10 at T -> rd_data_valid at T+8..T+11 with those four values in order; busy low at T+12.
- Write beat 0 = 0xFFFF_FFFF_FFFF_FFFF to addr 0x20 with mask 0, then rewrite 0x20 with data 0 and mask 8'h0F -> read beat 0 = 0x0000_0000_FFFF_FFFF.
- Write at addr 2^12 - 2 (0xFFE) -> beats land at words 0xFFE, 0xFFF, 0x000, 0x001. Read at addr 0x1000 returns the word-0 beat first, since it aliases to 0.
- cmd_en during INIT, and again at T+3 of a read -> cmd_error = 1; the read completes normally with 4 beats; a later valid command still works.
- Deassert rst_n at the 2nd valid read beat -> rd_data_valid and busy drop asynchronously. After re-init, earlier written data reads back intact.
